// File: rtl/jelly3_jfive_adder_arbiter.sv
// ---------------------------------------------------------------------------
// jelly3_jfive_adder
//   Registered XLEN-bit adder/subtractor with carry/borrow out.
//   Ports:
//     reset, clk, cke           : async active-high reset, clock, clock enable
//     s_sub_en, s_imm_en        : op select (sub_en -> subtract, imm_en -> use imm)
//     s_rs1_val/s_rs2_val/s_imm_val : operands
//     m_rd_val, m_carry         : registered result and bit XLEN of the sum
//
// jelly3_jfive_adder_arbiter
//   Shares one jelly3_jfive_adder among REQS requesters. The adder output
//   register is the result buffer; arbitration only advances when that buffer
//   is empty or being drained.
//   Ports:
//     reset, clk, cke           : async active-high reset, clock, clock enable
//     s_valid / s_ready         : per-requester handshake
//     s_sub_en, s_imm_en        : per-requester op (00 add, 01 add imm, 10 sub, 11 illegal)
//     s_rs1_val, s_rs2_val, s_imm_val, s_id : per-requester operands and tag
//     m_valid / m_ready         : result handshake
//     m_req, m_id, m_rd_val, m_carry, m_illegal : result record (zero when !m_valid)
//   Build option:
//     JELLY3_JFIVE_ADDER_ARB_ROUND_ROBIN_EN : round-robin arbitration;
//     undefined -> fixed priority, lowest valid index wins.
// ---------------------------------------------------------------------------

module jelly3_jfive_adder #(
    parameter int unsigned XLEN = 32
) (
    input  logic            reset,
    input  logic            clk,
    input  logic            cke,
    input  logic            s_sub_en,
    input  logic            s_imm_en,
    input  logic [XLEN-1:0] s_rs1_val,
    input  logic [XLEN-1:0] s_rs2_val,
    input  logic [XLEN-1:0] s_imm_val,
    output logic [XLEN-1:0] m_rd_val,
    output logic            m_carry
);

    logic [XLEN-1:0] opb;
    logic [XLEN:0]   sum_d;
    logic [XLEN:0]   sum_q;

    always_comb begin
        opb = s_imm_en ? s_imm_val : s_rs2_val;
        // Zero-extended to XLEN+1 so bit XLEN is the carry, or the borrow on subtract.
        if (s_sub_en) begin
            sum_d = {1'b0, s_rs1_val} - {1'b0, opb};
        end else begin
            sum_d = {1'b0, s_rs1_val} + {1'b0, opb};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (cke) begin
            sum_q <= sum_d;
        end
    end

    assign m_rd_val = sum_q[XLEN-1:0];
    assign m_carry  = sum_q[XLEN];

endmodule

module jelly3_jfive_adder_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REQS     = 4,
    parameter int unsigned ID_BITS  = 4,
    parameter int unsigned REQ_BITS = $clog2(REQS)
) (
    input  logic                          reset,
    input  logic                          clk,
    input  logic                          cke,

    input  logic [REQS-1:0]               s_valid,
    output logic [REQS-1:0]               s_ready,
    input  logic [REQS-1:0]               s_sub_en,
    input  logic [REQS-1:0]               s_imm_en,
    input  logic [REQS-1:0][XLEN-1:0]     s_rs1_val,
    input  logic [REQS-1:0][XLEN-1:0]     s_rs2_val,
    input  logic [REQS-1:0][XLEN-1:0]     s_imm_val,
    input  logic [REQS-1:0][ID_BITS-1:0]  s_id,

    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [REQ_BITS-1:0]           m_req,
    output logic [ID_BITS-1:0]            m_id,
    output logic [XLEN-1:0]               m_rd_val,
    output logic                          m_carry,
    output logic                          m_illegal
);

    logic                advance;
    logic                sel_valid;
    logic [REQ_BITS-1:0] sel_idx;
    logic [REQS-1:0]     grant;

    logic                valid_q;
    logic [REQ_BITS-1:0] req_q;
    logic [ID_BITS-1:0]  id_q;
    logic                illegal_q;

    logic [XLEN-1:0]     add_rd_val;
    logic                add_carry;

    // The result buffer can take a new entry when empty or drained this cycle.
    assign advance = cke && (!valid_q || m_ready);

`ifdef JELLY3_JFIVE_ADDER_ARB_ROUND_ROBIN_EN
    logic [REQ_BITS-1:0] ptr_q;
    logic [REQ_BITS-1:0] ptr_d;

    // Search upward from ptr+1, wrapping, so the last winner goes to the back.
    always_comb begin
        int unsigned pos;
        sel_valid = 1'b0;
        sel_idx   = '0;
        pos       = 0;
        for (int unsigned k = 1; k <= REQS; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= REQS) begin
                pos = pos - REQS;
            end
            if (!sel_valid && s_valid[REQ_BITS'(pos)]) begin
                sel_valid = 1'b1;
                sel_idx   = REQ_BITS'(pos);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && sel_valid) begin
            ptr_d = sel_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= REQ_BITS'(REQS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < REQS; k++) begin
            if (!sel_valid && s_valid[REQ_BITS'(k)]) begin
                sel_valid = 1'b1;
                sel_idx   = REQ_BITS'(k);
            end
        end
    end
`endif

    assign grant   = sel_valid ? (REQS'(1) << sel_idx) : '0;
    assign s_ready = advance ? grant : '0;

    jelly3_jfive_adder #(
        .XLEN (XLEN)
    ) u_adder (
        .reset     (reset),
        .clk       (clk),
        .cke       (advance),
        .s_sub_en  (s_sub_en[sel_idx]),
        .s_imm_en  (s_imm_en[sel_idx]),
        .s_rs1_val (s_rs1_val[sel_idx]),
        .s_rs2_val (s_rs2_val[sel_idx]),
        .s_imm_val (s_imm_val[sel_idx]),
        .m_rd_val  (add_rd_val),
        .m_carry   (add_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            req_q     <= '0;
            id_q      <= '0;
            illegal_q <= 1'b0;
        end else if (advance) begin
            valid_q   <= sel_valid;
            req_q     <= sel_valid ? sel_idx : '0;
            id_q      <= sel_valid ? s_id[sel_idx] : '0;
            illegal_q <= sel_valid && s_sub_en[sel_idx] && s_imm_en[sel_idx];
        end
    end

    // Arithmetic result is suppressed for illegal ops and whenever idle.
    assign m_valid   = valid_q;
    assign m_req     = valid_q ? req_q : '0;
    assign m_id      = valid_q ? id_q : '0;
    assign m_illegal = valid_q && illegal_q;
    assign m_rd_val  = (valid_q && !illegal_q) ? add_rd_val : '0;
    assign m_carry   = valid_q && !illegal_q && add_carry;

endmodule

// File: tb/tb_jelly3_jfive_adder_arbiter.sv
// Directed bench for jelly3_jfive_adder_arbiter (XLEN=32, REQS=4, ID_BITS=4).
// Expected arbitration order follows JELLY3_JFIVE_ADDER_ARB_ROUND_ROBIN_EN.

module tb_jelly3_jfive_adder_arbiter;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REQS     = 4;
    localparam int unsigned ID_BITS  = 4;
    localparam int unsigned REQ_BITS = 2;

    logic                         reset;
    logic                         clk;
    logic                         cke;
    logic [REQS-1:0]              s_valid;
    logic [REQS-1:0]              s_ready;
    logic [REQS-1:0]              s_sub_en;
    logic [REQS-1:0]              s_imm_en;
    logic [REQS-1:0][XLEN-1:0]    s_rs1_val;
    logic [REQS-1:0][XLEN-1:0]    s_rs2_val;
    logic [REQS-1:0][XLEN-1:0]    s_imm_val;
    logic [REQS-1:0][ID_BITS-1:0] s_id;
    logic                         m_valid;
    logic                         m_ready;
    logic [REQ_BITS-1:0]          m_req;
    logic [ID_BITS-1:0]           m_id;
    logic [XLEN-1:0]              m_rd_val;
    logic                         m_carry;
    logic                         m_illegal;

    int n_checks;
    int n_errors;

    jelly3_jfive_adder_arbiter #(
        .XLEN     (XLEN),
        .REQS     (REQS),
        .ID_BITS  (ID_BITS),
        .REQ_BITS (REQ_BITS)
    ) u_dut (
        .reset     (reset),
        .clk       (clk),
        .cke       (cke),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sub_en  (s_sub_en),
        .s_imm_en  (s_imm_en),
        .s_rs1_val (s_rs1_val),
        .s_rs2_val (s_rs2_val),
        .s_imm_val (s_imm_val),
        .s_id      (s_id),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_req     (m_req),
        .m_id      (m_id),
        .m_rd_val  (m_rd_val),
        .m_carry   (m_carry),
        .m_illegal (m_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic sub, input logic imm,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [3:0] id);
        s_valid[i]   = 1'b1;
        s_sub_en[i]  = sub;
        s_imm_en[i]  = imm;
        s_rs1_val[i] = a;
        s_rs2_val[i] = b;
        s_imm_val[i] = c;
        s_id[i]      = id;
    endtask

    task automatic check_rec(input string tag, input logic v, input logic [1:0] req,
                             input logic [3:0] id, input logic [31:0] rd,
                             input logic cy, input logic ill);
        check({tag, "_valid"},   m_valid,   v);
        check({tag, "_req"},     m_req,     req);
        check({tag, "_id"},      m_id,      id);
        check({tag, "_rd"},      m_rd_val,  rd);
        check({tag, "_carry"},   m_carry,   cy);
        check({tag, "_illegal"}, m_illegal, ill);
    endtask

    initial begin
        logic [1:0] rr_seq [5];
        logic [1:0] resume_req;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        cke       = 1'b1;
        m_ready   = 1'b1;
        s_valid   = '0;
        s_sub_en  = '0;
        s_imm_en  = '0;
        s_rs1_val = '0;
        s_rs2_val = '0;
        s_imm_val = '0;
        s_id      = '0;
`ifdef JELLY3_JFIVE_ADDER_ARB_ROUND_ROBIN_EN
        rr_seq     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        resume_req = 2'd1;
`else
        rr_seq     = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        resume_req = 2'd0;
`endif

        tick();
        tick();
        check_rec("reset", 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // Single request: 5 + 3 on requester 1, tag 7.
        set_req(1, 1'b0, 1'b0, 32'd5, 32'd3, 32'd0, 4'd7);
        #1;
        check("single_sready", s_ready, 4'b0010);
        tick();
        s_valid = '0;
        check_rec("single", 1'b1, 2'd1, 4'd7, 32'd8, 1'b0, 1'b0);
        tick();
        check_rec("idle", 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0);

        // Borrow on subtract, carry out on add-immediate, plain subtract.
        set_req(0, 1'b1, 1'b0, 32'd0, 32'd1, 32'd0, 4'd2);
        tick();
        s_valid = '0;
        check_rec("borrow", 1'b1, 2'd0, 4'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);
        set_req(2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 4'd3);
        tick();
        s_valid = '0;
        check_rec("carry", 1'b1, 2'd2, 4'd3, 32'd0, 1'b1, 1'b0);
        set_req(3, 1'b1, 1'b0, 32'd10, 32'd3, 32'd0, 4'd4);
        tick();
        s_valid = '0;
        check_rec("sub", 1'b1, 2'd3, 4'd4, 32'd7, 1'b0, 1'b0);

        // Illegal op 11 is accepted and completes with zeroed arithmetic.
        set_req(3, 1'b1, 1'b1, 32'd9, 32'd2, 32'd5, 4'd6);
        #1;
        check("illegal_sready", s_ready, 4'b1000);
        tick();
        s_valid = '0;
        check_rec("illegal", 1'b1, 2'd3, 4'd6, 32'd0, 1'b0, 1'b1);
        tick();
        check("illegal_clear", m_illegal, 1'b0);

        // Backpressure: record stays put while another requester waits.
        m_ready = 1'b0;
        set_req(1, 1'b0, 1'b0, 32'd100, 32'd23, 32'd0, 4'd5);
        tick();
        s_valid = '0;
        set_req(2, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 4'd9);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_sready", s_ready, 4'b0000);
            check_rec("bp_hold", 1'b1, 2'd1, 4'd5, 32'd123, 1'b0, 1'b0);
            tick();
        end
        check_rec("bp_hold_end", 1'b1, 2'd1, 4'd5, 32'd123, 1'b0, 1'b0);
        m_ready = 1'b1;
        #1;
        check("bp_release_sready", s_ready, 4'b0100);
        tick();
        s_valid = '0;
        check_rec("bp_next", 1'b1, 2'd2, 4'd9, 32'd3, 1'b0, 1'b0);

        // Asynchronous reset discards the in-flight result.
        set_req(1, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 4'd1);
        tick();
        s_valid = '0;
        check("midrst_before", m_valid, 1'b1);
        reset = 1'b1;
        #1;
        check_rec("midrst", 1'b0, 2'd0, 4'd0, 32'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        // Contention: all requesters valid, requester i computes 10*i + 1.
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b0, 1'b0, 32'(10 * i), 32'd1, 32'd0, 4'(i));
        end
        #1;
        check("cont_sready", s_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_rec("cont", 1'b1, rr_seq[k], 4'(rr_seq[k]),
                      32'(10 * int'(rr_seq[k]) + 1), 1'b0, 1'b0);
        end

        // Clock enable low: everything holds, including the arbitration pointer.
        cke = 1'b0;
        #1;
        check("cke_sready", s_ready, 4'b0000);
        tick();
        tick();
        check_rec("cke_hold", 1'b1, rr_seq[4], 4'(rr_seq[4]),
                  32'(10 * int'(rr_seq[4]) + 1), 1'b0, 1'b0);
        cke = 1'b1;
        #1;
        check("cke_resume_sready", s_ready, 4'(1) << resume_req);
        tick();
        s_valid = '0;
        check_rec("cke_resume", 1'b1, resume_req, 4'(resume_req),
                  32'(10 * int'(resume_req) + 1), 1'b0, 1'b0);
        tick();
        check("final_idle", m_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
